// File: rtl/mem_wb_pipe.sv
// MEM/WB elastic pipeline: DEPTH valid/ready register stages with write-back mux and forwarding lookup.
// Optional forwarding lookup is enabled by defining MEM_WB_PIPE_FWD_EN; otherwise the fwd outputs are tied to 0.
module mem_wb_pipe #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              WriteRegIn,
   input  logic              MemToRegIn,
   input  logic [DATA_W-1:0] dataMemoryDataIn,
   input  logic [DATA_W-1:0] ALUResultIn,
   input  logic [REG_W-1:0]  registerIn,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              WriteRegOut,
   output logic              MemToRegOut,
   output logic [DATA_W-1:0] dataMemoryDataOut,
   output logic [DATA_W-1:0] ALUResultOut,
   output logic [REG_W-1:0]  registerOut,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_we,
   output logic [2:0]        occupancy,
   input  logic [REG_W-1:0]  fwd_rs_addr,
   input  logic [REG_W-1:0]  fwd_rt_addr,
   output logic              fwd_rs_hit,
   output logic              fwd_rt_hit,
   output logic [DATA_W-1:0] fwd_rs_data,
   output logic [DATA_W-1:0] fwd_rt_data
);

   typedef struct packed {
      logic              we;
      logic              m2r;
      logic [DATA_W-1:0] mem;
      logic [DATA_W-1:0] alu;
      logic [REG_W-1:0]  rd;
   } entry_t;

   function automatic logic [DATA_W-1:0] wb_of(input entry_t e);
      return e.m2r ? e.mem : e.alu;
   endfunction

   entry_t           stage_q [DEPTH];
   entry_t           src_e   [DEPTH];
   entry_t           out_e;
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] src_v;
   logic [DEPTH-1:0] load;
   logic             acc;

   // NOTE: load[i] is written in closed form (out_ready or any empty slot at or after i)
   // instead of chaining load[i+1], so there is no combinational self-loop on the vector.
   always_comb begin
      acc  = 1'b0;
      load = '0;
      for (int i = 0; i < DEPTH; i++) begin
         acc = out_ready;
         for (int j = i; j < DEPTH; j++) acc = acc | ~valid_q[j];
         load[i] = acc;
      end
   end

   assign in_ready = load[0] & ~flush;

   always_comb begin
      src_v    = '0;
      src_v[0] = in_valid & in_ready;
      src_e[0] = '{we: WriteRegIn, m2r: MemToRegIn, mem: dataMemoryDataIn,
                   alu: ALUResultIn, rd: registerIn};
      for (int i = 1; i < DEPTH; i++) begin
         src_v[i] = valid_q[i-1];
         src_e[i] = stage_q[i-1];
      end
   end

   // NOTE: payload registers are reset as well as valid bits, so a freshly reset pipe
   // shows all-zero state even before the first entry is loaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (flush) begin
         valid_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (load[i]) begin
               valid_q[i] <= src_v[i];
               stage_q[i] <= src_e[i];
            end
         end
      end
   end

   assign out_valid         = valid_q[DEPTH-1];
   assign out_e             = out_valid ? stage_q[DEPTH-1] : '0;
   assign WriteRegOut       = out_e.we;
   assign MemToRegOut       = out_e.m2r;
   assign dataMemoryDataOut = out_e.mem;
   assign ALUResultOut      = out_e.alu;
   assign registerOut       = out_e.rd;
   assign wb_data           = wb_of(out_e);
   assign wb_we             = out_valid & out_ready & out_e.we & ~flush;

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) occupancy = occupancy + 3'(valid_q[i]);
   end

`ifdef MEM_WB_PIPE_FWD_EN
   // Scan oldest to youngest so the lowest-index match is the last one written.
   always_comb begin
      fwd_rs_hit  = 1'b0;
      fwd_rt_hit  = 1'b0;
      fwd_rs_data = '0;
      fwd_rt_data = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (valid_q[i] && stage_q[i].we && stage_q[i].rd == fwd_rs_addr && fwd_rs_addr != '0) begin
            fwd_rs_hit  = 1'b1;
            fwd_rs_data = wb_of(stage_q[i]);
         end
         if (valid_q[i] && stage_q[i].we && stage_q[i].rd == fwd_rt_addr && fwd_rt_addr != '0) begin
            fwd_rt_hit  = 1'b1;
            fwd_rt_data = wb_of(stage_q[i]);
         end
      end
   end
`else
   logic unused_fwd;
   assign unused_fwd  = ^{fwd_rs_addr, fwd_rt_addr};
   assign fwd_rs_hit  = 1'b0;
   assign fwd_rt_hit  = 1'b0;
   assign fwd_rs_data = '0;
   assign fwd_rt_data = '0;
`endif

endmodule
